pe: RTL and testbench
=====================

# pe

Compare-exchange processing element for the 2-D mesh sorter. Each cycle it takes its own cell value and its left neighbour's value and emits the ordered pair: one value kept in place (`out_value`), the other handed back toward the neighbour (`pass_value`). The sort direction is selected per instance, so snake-order rows can use alternating directions. The block also provides a valid flag, a swap indicator and an optional swap counter for convergence detection by the mesh controller.

## Interface
Parameters:
- `WIDTH`, default 8: data width of every value port.
- `COUNT_WIDTH`, default 8: width of `swap_count`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_value`  in  WIDTH  this cell's current value.
- `neighbor_value`  in  WIDTH  left neighbour's value; the mesh drives 0 for column 0.
- `compare_direction`  in  1  0 = ascending (larger value stays), 1 = descending (smaller value stays).
- `in_valid`  in  1  operands are valid this cycle.
- `clear`  in  1  synchronous clear of `swap_count`.
- `out_value`  out  WIDTH  registered value kept by this cell.
- `pass_value`  out  WIDTH  registered value passed to the neighbour.
- `out_valid`  out  1  registered copy of `in_valid`.
- `swapped`  out  1  registered; 1 when the pair was out of order for the selected direction.
- `swap_count`  out  COUNT_WIDTH  number of swaps since reset or `clear`.

## Operation
- Comparison is unsigned, full WIDTH.
- Ascending (`compare_direction`=0): `out_value` = max(`in_value`, `neighbor_value`), `pass_value` = min. `swapped` = (`neighbor_value` > `in_value`).
- Descending (`compare_direction`=1): `out_value` = min, `pass_value` = max. `swapped` = (`neighbor_value` < `in_value`).
- Equal operands: no swap. `out_value` = `pass_value` = the common value, `swapped` = 0.
- If `in_valid`=0, then `out_value`, `pass_value` and `swapped` hold their previous values, and `out_valid` goes to 0.
- `swap_count` increments on each registered swap (`in_valid`=1 and out of order) and saturates at all-ones; it never wraps.
- `clear`=1 forces `swap_count` to 0 on the next edge. This takes priority over an increment in the same cycle.
- `compare_direction` is sampled each cycle. Changing it while running is legal and takes effect on the next edge.

## Timing
- Latency is one cycle. Operands sampled at edge n appear on the outputs after edge n.
- Throughput is one compare per cycle. There is no backpressure or stall input.
- When `reset` goes low, all outputs go to 0 immediately: `out_value`, `pass_value`, `out_valid`, `swapped`, `swap_count`.
- Reset asserted mid-stream discards the in-flight result. The first valid output after release appears one cycle after the first sampled `in_valid`=1.
- Release of `reset` is assumed to be synchronised externally to `clk`.

## Configuration
- Macro: `PE_SWAP_COUNT_EN`.
- Defined: the `swap_count` register and its saturation and clear logic are built as described above.
- Undefined: `swap_count` is tied to 0, `clear` is ignored, and no counter flops are built. All other behaviour is identical. The port list is unchanged in both cases.

## Test plan
- Reset: assert `reset`=0 mid-run with nonzero outputs -> all outputs 0 immediately, with no clock edge required.
- Ascending swap: `in_value`=5, `neighbor_value`=9, dir=0, valid=1 -> next cycle `out_value`=9, `pass_value`=5, `swapped`=1, `swap_count`=1.
- Descending, no swap: `in_value`=3, `neighbor_value`=200, dir=1 -> `out_value`=3, `pass_value`=200, `swapped`=0, count unchanged.
- Equal and extreme values: 0x80/0x80 -> both outputs 0x80, `swapped`=0. Then 0xFF/0x00 with dir=0 -> `out_value`=0xFF, `pass_value`=0x00, `swapped`=0 (unsigned comparison confirmed).
- Hold: `in_valid`=0 with new operands -> outputs unchanged, `out_valid`=0.
- Counter (macro defined, COUNT_WIDTH=2): 5 consecutive swaps -> count reads 1, 2, 3, 3, 3. Then `clear`=1 together with a swap -> 0. Same sequence with the macro undefined -> `swap_count` stays 0.

Source files
------------

// File: rtl/pe.sv
// Compare-exchange processing element for the 2-D mesh sorter.
// Optional swap counter is built only when PE_SWAP_COUNT_EN is defined.
module pe #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_value,
  input  logic [WIDTH-1:0]       neighbor_value,
  input  logic                   compare_direction,
  input  logic                   in_valid,
  input  logic                   clear,
  output logic [WIDTH-1:0]       out_value,
  output logic [WIDTH-1:0]       pass_value,
  output logic                   out_valid,
  output logic                   swapped,
  output logic [COUNT_WIDTH-1:0] swap_count
);

  logic [WIDTH-1:0] max_s;
  logic [WIDTH-1:0] min_s;
  logic             swap_s;

  logic [WIDTH-1:0] out_value_d,  out_value_q;
  logic [WIDTH-1:0] pass_value_d, pass_value_q;
  logic             out_valid_d,  out_valid_q;
  logic             swapped_d,    swapped_q;

  // Order the pair and decide whether it was out of order for this direction
  always_comb begin
    max_s  = in_value;
    min_s  = neighbor_value;
    swap_s = 1'b0;
    if (neighbor_value > in_value) begin
      max_s = neighbor_value;
      min_s = in_value;
    end else begin
      max_s = in_value;
      min_s = neighbor_value;
    end
    case (compare_direction)
      1'b0:    swap_s = (neighbor_value > in_value);
      1'b1:    swap_s = (neighbor_value < in_value);
      default: swap_s = 1'b0;
    endcase
  end

  // Next-state for the data outputs; invalid cycles hold the last result
  always_comb begin
    out_value_d  = out_value_q;
    pass_value_d = pass_value_q;
    swapped_d    = swapped_q;
    out_valid_d  = in_valid;
    if (in_valid) begin
      swapped_d = swap_s;
      if (compare_direction) begin
        out_value_d  = min_s;
        pass_value_d = max_s;
      end else begin
        out_value_d  = max_s;
        pass_value_d = min_s;
      end
    end else begin
      out_value_d  = out_value_q;
      pass_value_d = pass_value_q;
      swapped_d    = swapped_q;
    end
  end

  // Result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_value_q  <= {WIDTH{1'b0}};
      pass_value_q <= {WIDTH{1'b0}};
      out_valid_q  <= 1'b0;
      swapped_q    <= 1'b0;
    end else begin
      out_value_q  <= out_value_d;
      pass_value_q <= pass_value_d;
      out_valid_q  <= out_valid_d;
      swapped_q    <= swapped_d;
    end
  end

  assign out_value  = out_value_q;
  assign pass_value = pass_value_q;
  assign out_valid  = out_valid_q;
  assign swapped    = swapped_q;

`ifdef PE_SWAP_COUNT_EN
  logic [COUNT_WIDTH-1:0] swap_count_d, swap_count_q;

  // Saturating swap counter; clear wins over an increment in the same cycle
  always_comb begin
    swap_count_d = swap_count_q;
    if (clear) begin
      swap_count_d = {COUNT_WIDTH{1'b0}};
    end else if (in_valid && swap_s && (swap_count_q != {COUNT_WIDTH{1'b1}})) begin
      swap_count_d = swap_count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      swap_count_d = swap_count_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swap_count_q <= {COUNT_WIDTH{1'b0}};
    end else begin
      swap_count_q <= swap_count_d;
    end
  end

  assign swap_count = swap_count_q;
`else
  logic unused_clear_s;

  assign unused_clear_s = clear;
  assign swap_count     = {COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pe.sv
// Directed self-checking bench for the pe compare-exchange element.
module tb_pe;
  localparam int WIDTH = 8;
  localparam int CW    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_value;
  logic [WIDTH-1:0] neighbor_value;
  logic             compare_direction;
  logic             in_valid;
  logic             clear;
  logic [WIDTH-1:0] out_value;
  logic [WIDTH-1:0] pass_value;
  logic             out_valid;
  logic             swapped;
  logic [CW-1:0]    swap_count;

  int checks = 0;
  int errors = 0;

  pe #(.WIDTH(WIDTH), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_value(in_value), .neighbor_value(neighbor_value),
    .compare_direction(compare_direction), .in_valid(in_valid), .clear(clear),
    .out_value(out_value), .pass_value(pass_value), .out_valid(out_valid),
    .swapped(swapped), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  function automatic int cexp(input int v);
`ifdef PE_SWAP_COUNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ov, input int pv, input int vl,
                           input int sw, input int cnt);
    check({tag, ".out_value"},  int'(out_value),  ov);
    check({tag, ".pass_value"}, int'(pass_value), pv);
    check({tag, ".out_valid"},  int'(out_valid),  vl);
    check({tag, ".swapped"},    int'(swapped),    sw);
    check({tag, ".swap_count"}, int'(swap_count), cnt);
  endtask

  task automatic drive(input int iv, input int nv, input logic dir, input logic vld,
                       input logic clr);
    in_value          = iv[WIDTH-1:0];
    neighbor_value    = nv[WIDTH-1:0];
    compare_direction = dir;
    in_valid          = vld;
    clear             = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_value = '0; neighbor_value = '0;
    compare_direction = 1'b0; in_valid = 1'b0; clear = 1'b0;
    @(posedge clk); #1;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    drive(5, 9, 1'b0, 1'b1, 1'b0);
    check_all("asc_swap", 9, 5, 1, 1, cexp(1));
    drive(3, 200, 1'b1, 1'b1, 1'b0);
    check_all("desc_noswap", 3, 200, 1, 0, cexp(1));
    drive(8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
    check_all("equal", 8'h80, 8'h80, 1, 0, cexp(1));
    drive(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    check_all("unsigned", 8'hFF, 8'h00, 1, 0, cexp(1));
    drive(10, 20, 1'b0, 1'b1, 1'b0);
    check_all("asc_swap2", 20, 10, 1, 1, cexp(2));
    drive(7, 3, 1'b1, 1'b0, 1'b0);
    check_all("hold", 20, 10, 0, 1, cexp(2));
    drive(50, 40, 1'b1, 1'b1, 1'b0);
    check_all("desc_swap", 40, 50, 1, 1, cexp(3));
    drive(50, 40, 1'b0, 1'b1, 1'b0);
    check_all("dir_change", 50, 40, 1, 0, cexp(3));
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    check("clear", int'(swap_count), 0);

    drive(1, 2, 1'b0, 1'b1, 1'b0); check("sat1", int'(swap_count), cexp(1));
    drive(1, 2, 1'b0, 1'b1, 1'b0); check("sat2", int'(swap_count), cexp(2));
    drive(1, 2, 1'b0, 1'b1, 1'b0); check("sat3", int'(swap_count), cexp(3));
    drive(1, 2, 1'b0, 1'b1, 1'b0); check("sat4", int'(swap_count), cexp(3));
    drive(1, 2, 1'b0, 1'b1, 1'b0); check("sat5", int'(swap_count), cexp(3));
    drive(1, 2, 1'b0, 1'b1, 1'b1);
    check_all("clear_prio", 2, 1, 1, 1, 0);

    // Asynchronous reset away from any clock edge
    drive(1, 2, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(9, 4, 1'b1, 1'b0, 1'b0);
    check_all("post_reset_idle", 0, 0, 0, 0, 0);
    drive(9, 4, 1'b1, 1'b1, 1'b0);
    check_all("post_reset_first", 4, 9, 1, 1, cexp(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
